// File: rtl/frame_stream_checker_if.sv
// FIFO-side bus of the frame checker: DUT output FIFO and ground-truth FIFO, both first-word fall-through.
// Latency: none, wires only; rd_en and dout/empty are sampled on the consumer's clock edge.
// Backpressure: the checker (master) pops with rd_en; the FIFO side (slave) stalls it with empty.
interface frame_stream_checker_if #(
    parameter int DWIDTH   = 8,
    parameter int CHANNELS = 3
);
    logic [DWIDTH-1:0]          dut_dout;
    logic                       dut_empty;
    logic                       dut_rd_en;
    logic [DWIDTH*CHANNELS-1:0] gt_dout;
    logic                       gt_empty;
    logic                       gt_rd_en;

    // Checker side: consumes both FIFOs.
    modport master (
        input  dut_dout, dut_empty, gt_dout, gt_empty,
        output dut_rd_en, gt_rd_en
    );

    // FIFO side: presents data and empty flags, receives the pops.
    modport slave (
        output dut_dout, dut_empty, gt_dout, gt_empty,
        input  dut_rd_en, gt_rd_en
    );
endinterface

// File: rtl/frame_stream_checker.sv
// Frame checker: pops DUT and ground-truth FIFOs in lockstep, compares each pixel within TOLERANCE.
// Latency: mismatch and counts are registered 1 cycle after the pop; done coincides with final counts.
// Backpressure: pops only while both FIFOs are non-empty; macro CHECKER_TIMEOUT_EN adds a stall watchdog.
module frame_stream_checker #(
    parameter int IMG_WIDTH      = 64,
    parameter int IMG_HEIGHT     = 32,
    parameter int DWIDTH         = 8,
    parameter int CHANNELS       = 3,
    parameter int TOLERANCE      = 0,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    frame_stream_checker_if.master fifo,
    output logic                  busy,
    output logic                  done,
    output logic                  mismatch,
    output logic [CNT_WIDTH-1:0]  pixel_count,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic [XW-1:0]         first_err_x,
    output logic [YW-1:0]         first_err_y,
    output logic                  first_err_vld,
    output logic                  timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XW-1:0]     X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [DWIDTH:0]   TOL    = (DWIDTH + 1)'(TOLERANCE);

    // Elaboration-time sanity checks on the geometry and watchdog limit.
    if (IMG_WIDTH < 1 || IMG_HEIGHT < 1) begin : g_bad_geometry
        $error("frame_stream_checker: IMG_WIDTH and IMG_HEIGHT must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("frame_stream_checker: TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]        state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              pop;
    logic              pix_ok;
    logic              start_frame;
    logic              last_pix;
    logic              stall_hit;
    logic [DWIDTH-1:0] gt_s;
    logic [DWIDTH:0]   diff;

    assign busy        = (state == S_RUN);
    assign done        = (state == S_DONE);
    assign start_frame = start && (state == S_IDLE);
    assign last_pix    = (x == X_LAST) && (y == Y_LAST);

    // Both FIFOs always pop together, only when each has a word ready.
    assign pop            = busy && !fifo.dut_empty && !fifo.gt_empty;
    assign fifo.dut_rd_en = pop;
    assign fifo.gt_rd_en  = pop;

    // Per-channel absolute difference at DWIDTH+1 bits; the pixel matches only if every channel is in tolerance.
    always_comb begin
        pix_ok = 1'b1;
        gt_s   = '0;
        diff   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            gt_s = fifo.gt_dout[c*DWIDTH +: DWIDTH];
            diff = (fifo.dut_dout >= gt_s) ? ({1'b0, fifo.dut_dout} - {1'b0, gt_s})
                                           : ({1'b0, gt_s} - {1'b0, fifo.dut_dout});
            if (diff > TOL) begin
                pix_ok = 1'b0;
            end
        end
    end

`ifdef CHECKER_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0] stall_cnt;

    // The watchdog fires on the TIMEOUT_CYCLES-th consecutive cycle without a pop.
    assign stall_hit = busy && !pop && (stall_cnt == SW'(TIMEOUT_CYCLES - 1));

    // Stall counter: cleared by a new frame and by every pop, otherwise counts RUN cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (start_frame || pop) begin
            stall_cnt <= '0;
        end else if (busy) begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end

    // Sticky timeout flag, cleared only when the next frame starts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout <= 1'b0;
        end else if (start_frame) begin
            timeout <= 1'b0;
        end else if (stall_hit) begin
            timeout <= 1'b1;
        end
    end
`else
    assign stall_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Frame FSM: IDLE waits for start, RUN until the last pixel or watchdog, DONE lasts one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if ((pop && last_pix) || stall_hit) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result registers and raster position: cleared on start, updated on each pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mismatch      <= 1'b0;
            pixel_count   <= '0;
            error_count   <= '0;
            first_err_x   <= '0;
            first_err_y   <= '0;
            first_err_vld <= 1'b0;
            x             <= '0;
            y             <= '0;
        end else begin
            mismatch <= pop && !pix_ok;
            if (start_frame) begin
                pixel_count   <= '0;
                error_count   <= '0;
                first_err_x   <= '0;
                first_err_y   <= '0;
                first_err_vld <= 1'b0;
                x             <= '0;
                y             <= '0;
            end else if (pop) begin
                pixel_count <= pixel_count + CNT_WIDTH'(1);
                if (!pix_ok) begin
                    if (error_count != '1) begin
                        error_count <= error_count + CNT_WIDTH'(1);
                    end
                    if (!first_err_vld) begin
                        first_err_x   <= x;
                        first_err_y   <= y;
                        first_err_vld <= 1'b1;
                    end
                end
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_stream_checker.sv
// Bench for frame_stream_checker: 4x2 frame, 3 channels, FIFO models driven from queues.
// Latency: scoreboard expects mismatch one cycle after each pop; results checked when done pulses.
// Backpressure: empty flags come from queue occupancy plus per-test stall overrides.
module tb_frame_stream_checker;

    localparam int W = 4;
    localparam int H = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clock = ~clock;

    frame_stream_checker_if #(.DWIDTH(8), .CHANNELS(3)) ifc ();
    frame_stream_checker_if #(.DWIDTH(8), .CHANNELS(3)) ifc2 ();

    // Second instance (TOLERANCE=2, 2-bit counters) sees identical FIFO data and flags.
    assign ifc2.dut_dout  = ifc.dut_dout;
    assign ifc2.dut_empty = ifc.dut_empty;
    assign ifc2.gt_dout   = ifc.gt_dout;
    assign ifc2.gt_empty  = ifc.gt_empty;

    logic        busy, done, mismatch, first_err_vld, timeout;
    logic [31:0] pixel_count, error_count;
    logic [1:0]  first_err_x;
    logic [0:0]  first_err_y;
    logic        busy2, done2, mismatch2, first_err_vld2, timeout2;
    logic [1:0]  pixel_count2, error_count2;
    logic [1:0]  first_err_x2;
    logic [0:0]  first_err_y2;

    frame_stream_checker #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(8), .CHANNELS(3),
        .TOLERANCE(0), .CNT_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .fifo(ifc.master),
        .busy(busy), .done(done), .mismatch(mismatch),
        .pixel_count(pixel_count), .error_count(error_count),
        .first_err_x(first_err_x), .first_err_y(first_err_y),
        .first_err_vld(first_err_vld), .timeout(timeout)
    );

    frame_stream_checker #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(8), .CHANNELS(3),
        .TOLERANCE(2), .CNT_WIDTH(2), .TIMEOUT_CYCLES(16)
    ) dut_tol2 (
        .clock(clock), .reset(reset), .start(start), .fifo(ifc2.master),
        .busy(busy2), .done(done2), .mismatch(mismatch2),
        .pixel_count(pixel_count2), .error_count(error_count2),
        .first_err_x(first_err_x2), .first_err_y(first_err_y2),
        .first_err_vld(first_err_vld2), .timeout(timeout2)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  dq[$];
    logic [23:0] gq[$];
    logic [1:0]  sb[$];
    logic        dut_block = 1'b0;
    logic        gt_block = 1'b0;
    logic        last_pop = 1'b0;
    int          nd_pops, ng_pops;
    int          exp_pix, exp_err, exp_err2, mx, my;

    // Reference compare: every channel within tol of the replicated DUT sample.
    function automatic logic px_ok(input logic [7:0] d, input logic [23:0] g, input int tol);
        logic [23:0] gv;
        int a, b, df;
        px_ok = 1'b1;
        gv = g;
        for (int c = 0; c < 3; c++) begin
            a  = int'(d);
            b  = int'(gv[c*8 +: 8]);
            df = (a > b) ? a - b : b - a;
            if (df > tol) px_ok = 1'b0;
        end
    endfunction

    task automatic refresh();
        ifc.dut_empty = (dq.size() == 0) || dut_block;
        ifc.gt_empty  = (gq.size() == 0) || gt_block;
        ifc.dut_dout  = (dq.size() != 0) ? dq[0] : 8'h00;
        ifc.gt_dout   = (gq.size() != 0) ? gq[0] : 24'h0;
    endtask

    task automatic clear_model();
        exp_pix = 0; exp_err = 0; exp_err2 = 0; mx = 0; my = 0;
        nd_pops = 0; ng_pops = 0;
        sb.delete();
    endtask

    // kind 0: all match; 1: pixel 6 off by 2 per channel; 2: all far off; 3: pixels 1 and 5 far off.
    task automatic load_frame(input int n_dut, input int kind);
        logic [7:0] d;
        logic [23:0] g;
        dq.delete();
        gq.delete();
        for (int i = 0; i < W * H; i++) begin
            d = 8'(i * 16 + 3);
            g = {d, d, d};
            if (kind == 1 && i == 6) begin d = 8'h12; g = 24'h101010; end
            if (kind == 2) begin d = 8'h00; g = 24'h808080; end
            if (kind == 3 && (i == 1 || i == 5)) d = d ^ 8'h40;
            if (i < n_dut) dq.push_back(d);
            gq.push_back(g);
        end
        refresh();
    endtask

    // One clock: sample pops at negedge, push expectation, check the registered mismatch after the edge.
    task automatic step(input logic st);
        logic p_d, p_g, ok0, ok2;
        logic [1:0] e, act;
        @(negedge clock);
        start = st;
        p_d = ifc.dut_rd_en;
        p_g = ifc.gt_rd_en;
        n_chk++;
        if (p_d !== p_g) begin
            n_fail++;
            $display("FAIL pop_pair: dut_rd_en=%b gt_rd_en=%b required equal", p_d, p_g);
        end
        if (p_d === 1'b1 && dq.size() != 0 && gq.size() != 0) begin
            ok0 = px_ok(dq[0], gq[0], 0);
            ok2 = px_ok(dq[0], gq[0], 2);
            sb.push_back({!ok2, !ok0});
            exp_pix++;
            if (!ok0) exp_err++;
            if (!ok2 && exp_err2 < 3) exp_err2++;
            if (mx == W - 1) begin mx = 0; my = (my == H - 1) ? 0 : my + 1; end
            else mx++;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        last_pop = (p_d === 1'b1);
        if (p_d === 1'b1) begin nd_pops++; if (dq.size() != 0) void'(dq.pop_front()); end
        if (p_g === 1'b1) begin ng_pops++; if (gq.size() != 0) void'(gq.pop_front()); end
        act = {mismatch2, mismatch};
        e = (p_d === 1'b1 && sb.size() != 0) ? sb.pop_front() : 2'b00;
        n_chk++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL mismatch_pulse: got {tol2,tol0}=%b required %b", act, e);
        end
        refresh();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        refresh();
        @(posedge clock);
        #1;
        n_chk++;
        if ({busy, done, mismatch, first_err_vld, timeout, ifc.dut_rd_en, ifc.gt_rd_en} !== 7'b0
            || pixel_count !== 32'd0 || error_count !== 32'd0 || first_err_x !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b pix=%0d err=%0d required all 0",
                     busy, done, pixel_count, error_count);
        end
        reset = 1'b0;
        step(1'b0);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: busy=%b required 0", busy);
        end
    endtask

    task automatic test_match_frame();
        int cycles = 0;
        logic got = 1'b0;
        clear_model();
        load_frame(8, 0);
        dq.push_back(8'hAA);
        gq.push_back(24'hAAAAAA);
        refresh();
        step(1'b1);
        while (!got && cycles < 40) begin
            step(1'b0);
            cycles++;
            got = (done === 1'b1);
        end
        n_chk++;
        if (!got || cycles != 8 || nd_pops != 8) begin
            n_fail++;
            $display("FAIL match_latency: done=%b after %0d cycles, pops=%0d required 8/8", got, cycles, nd_pops);
        end
        n_chk++;
        if (pixel_count !== 32'd8 || error_count !== 32'd0 || first_err_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL match_counts: pix=%0d err=%0d vld=%b required 8/0/0",
                     pixel_count, error_count, first_err_vld);
        end
        step(1'b0);
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0 || dq.size() != 1 || gq.size() != 1) begin
            n_fail++;
            $display("FAIL match_done_one_cycle: done=%b busy=%b left=%0d/%0d required 0/0/1/1",
                     done, busy, dq.size(), gq.size());
        end
    endtask

    task automatic test_pixel_error();
        int cycles = 0;
        logic got = 1'b0;
        clear_model();
        load_frame(8, 1);
        step(1'b1);
        while (!got && cycles < 40) begin
            step(1'b0);
            cycles++;
            got = (done === 1'b1);
        end
        n_chk++;
        if (!got || error_count !== 32'd1 || exp_err != 1 || pixel_count !== 32'd8) begin
            n_fail++;
            $display("FAIL err_count: done=%b err=%0d pix=%0d required 1/1/8", got, error_count, pixel_count);
        end
        n_chk++;
        if (first_err_vld !== 1'b1 || first_err_x !== 2'd2 || first_err_y !== 1'b1) begin
            n_fail++;
            $display("FAIL err_first: vld=%b x=%0d y=%0d required 1,2,1", first_err_vld, first_err_x, first_err_y);
        end
        n_chk++;
        if (error_count2 !== 2'd0 || first_err_vld2 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_tol2: err=%0d vld=%b required 0/0", error_count2, first_err_vld2);
        end
        step(1'b0);
    endtask

    task automatic test_gt_stall();
        int cycles = 0;
        int viol = 0;
        logic got = 1'b0;
        clear_model();
        load_frame(8, 0);
        step(1'b1);
        while (!got && cycles < 60) begin
            gt_block = cycles[0];
            refresh();
            step(1'b0);
            if (gt_block && last_pop) viol++;
            cycles++;
            got = (done === 1'b1);
        end
        gt_block = 1'b0;
        refresh();
        n_chk++;
        if (viol != 0 || nd_pops != 8 || ng_pops != 8) begin
            n_fail++;
            $display("FAIL stall_pops: viol=%0d dut_pops=%0d gt_pops=%0d required 0/8/8", viol, nd_pops, ng_pops);
        end
        n_chk++;
        if (!got || pixel_count !== 32'd8 || error_count !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_done: done=%b pix=%0d err=%0d required 1/8/0", got, pixel_count, error_count);
        end
        step(1'b0);
    endtask

    task automatic test_async_reset();
        int cycles = 0;
        int dones = 0;
        logic got = 1'b0;
        clear_model();
        load_frame(8, 3);
        step(1'b1);
        repeat (3) step(1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_chk++;
        if ({busy, done, mismatch, first_err_vld, ifc.dut_rd_en, ifc.gt_rd_en} !== 6'b0
            || pixel_count !== 32'd0 || error_count !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b rd=%b pix=%0d err=%0d required 0/0/0/0",
                     busy, ifc.dut_rd_en, pixel_count, error_count);
        end
        repeat (3) begin
            @(posedge clock);
            #1;
            if (done !== 1'b0) dones++;
        end
        n_chk++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: done seen %0d times required 0", dones);
        end
        reset = 1'b0;
        clear_model();
        load_frame(8, 0);
        step(1'b1);
        while (!got && cycles < 40) begin
            step(1'b0);
            cycles++;
            got = (done === 1'b1);
        end
        n_chk++;
        if (!got || pixel_count !== 32'd8 || error_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_restart: done=%b pix=%0d err=%0d required 1/8/0", got, pixel_count, error_count);
        end
        step(1'b0);
    endtask

    task automatic test_start_ignored();
        int cycles = 0;
        logic got = 1'b0;
        clear_model();
        load_frame(8, 3);
        step(1'b1);
        repeat (3) step(1'b0);
        step(1'b1);
        n_chk++;
        if (pixel_count !== 32'd4 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_run: pix=%0d busy=%b required 4/1", pixel_count, busy);
        end
        while (!got && cycles < 40) begin
            step(1'b0);
            cycles++;
            got = (done === 1'b1);
        end
        n_chk++;
        if (!got || pixel_count !== 32'd8 || error_count !== 32'd2 || error_count2 !== 2'd2
            || first_err_x !== 2'd1 || first_err_y !== 1'b0 || exp_err != 2) begin
            n_fail++;
            $display("FAIL two_errors: pix=%0d err=%0d err2=%0d x=%0d y=%0d required 8/2/2/1/0",
                     pixel_count, error_count, error_count2, first_err_x, first_err_y);
        end
        step(1'b1);
        n_chk++;
        if (busy !== 1'b0 || pixel_count !== 32'd8) begin
            n_fail++;
            $display("FAIL start_in_done: busy=%b pix=%0d required 0/8", busy, pixel_count);
        end
        clear_model();
        load_frame(8, 0);
        step(1'b1);
        n_chk++;
        if (busy !== 1'b1 || pixel_count !== 32'd0 || error_count !== 32'd0 || first_err_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clears: busy=%b pix=%0d err=%0d vld=%b required 1/0/0/0",
                     busy, pixel_count, error_count, first_err_vld);
        end
        cycles = 0;
        got = 1'b0;
        while (!got && cycles < 40) begin
            step(1'b0);
            cycles++;
            got = (done === 1'b1);
        end
        step(1'b0);
    endtask

    task automatic test_saturate();
        int cycles = 0;
        logic got = 1'b0;
        clear_model();
        load_frame(8, 2);
        step(1'b1);
        while (!got && cycles < 40) begin
            step(1'b0);
            cycles++;
            got = (done === 1'b1);
        end
        n_chk++;
        if (!got || error_count !== 32'(exp_err) || error_count2 !== 2'(exp_err2) || error_count2 !== 2'd3) begin
            n_fail++;
            $display("FAIL saturate: err=%0d err2=%0d required %0d/%0d", error_count, error_count2, exp_err, exp_err2);
        end
        n_chk++;
        if (first_err_x !== 2'd0 || first_err_y !== 1'b0 || first_err_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate_first: x=%0d y=%0d vld=%b required 0,0,1", first_err_x, first_err_y, first_err_vld);
        end
        step(1'b0);
    endtask

    task automatic test_timeout();
        int cycles = 0;
        logic got = 1'b0;
        clear_model();
        load_frame(5, 0);
        step(1'b1);
        while (!got && cycles < 60) begin
            step(1'b0);
            cycles++;
            got = (done === 1'b1);
        end
`ifdef CHECKER_TIMEOUT_EN
        n_chk++;
        if (!got || cycles != 21 || timeout !== 1'b1 || pixel_count !== 32'd5) begin
            n_fail++;
            $display("FAIL timeout_fire: done=%b cycles=%0d to=%b pix=%0d required 1/21/1/5",
                     got, cycles, timeout, pixel_count);
        end
        step(1'b0);
        n_chk++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky: to=%b busy=%b required 1/0", timeout, busy);
        end
`else
        n_chk++;
        if (got || busy !== 1'b1 || timeout !== 1'b0 || pixel_count !== 32'd5) begin
            n_fail++;
            $display("FAIL no_timeout: done=%b busy=%b to=%b pix=%0d required 0/1/0/5",
                     got, busy, timeout, pixel_count);
        end
`endif
        reset = 1'b1;
        #2;
        reset = 1'b0;
        dq.delete();
        gq.delete();
        refresh();
    endtask

    initial begin
        ifc.dut_dout  = 8'h00;
        ifc.gt_dout   = 24'h0;
        ifc.dut_empty = 1'b1;
        ifc.gt_empty  = 1'b1;
        clear_model();
        test_reset();
        test_match_frame();
        test_pixel_error();
        test_gt_stall();
        test_async_reset();
        test_start_ignored();
        test_saturate();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "bench watchdog expired");
    end

endmodule
